// File: rtl/pm_thread_dispatch.sv
// pm_thread_dispatch: splits a job (base, length in lines) into up to 2**TID_W
// contiguous per-thread chunks. It issues one command per thread over valid/ready,
// then collects the per-thread completion pulses and raises a one-cycle done.
module pm_thread_dispatch #(
   parameter int TID_W      = 2,
   parameter int ADDR_W     = 32,
   parameter int LEN_W      = 16,
   parameter int LINE_SHIFT = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     job_base,
   input  logic [LEN_W-1:0]      job_len,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [TID_W-1:0]      cmd_tid,
   output logic [ADDR_W-1:0]     cmd_addr,
   output logic [LEN_W-1:0]      cmd_len,
   input  logic [(2**TID_W)-1:0] thr_done,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   localparam int NT = 2**TID_W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [TID_W-1:0]  tid_q, tid_d;
   logic [TID_W-1:0]  r_q, r_d;
   logic [LEN_W-1:0]  q_q, q_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [NT-1:0]     pend_q, pend_d;
   logic              err_q, err_d;

   logic [LEN_W-1:0]  job_q;
   logic [TID_W-1:0]  job_r;
   logic [TID_W-1:0]  tid_nxt;
   logic [LEN_W-1:0]  len_nxt;

   assign job_q   = job_len >> TID_W;
   assign job_r   = job_len[TID_W-1:0];
   assign tid_nxt = tid_q + TID_W'(1);
   // The low-numbered threads take the remainder lines, so chunk lengths never increase with tid.
   assign len_nxt = q_q + LEN_W'(tid_nxt < r_q);

   // Next-state logic. The payload is held in registers and advanced only on a handshake.
   always_comb begin
      state_d = state_q;
      tid_d   = tid_q;
      r_d     = r_q;
      q_d     = q_q;
      len_d   = len_q;
      addr_d  = addr_q;
      pend_d  = pend_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d  = job_base;
               q_d     = job_q;
               r_d     = job_r;
               tid_d   = '0;
               len_d   = job_q + LEN_W'(job_r != '0);
               pend_d  = '0;
               err_d   = 1'b0;
               state_d = (job_len == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            pend_d = pend_q & ~thr_done;
            if (cmd_ready) begin
               // Setting the bit comes after the clear, so an issue beats a same-cycle completion.
               pend_d[tid_q] = 1'b1;
               tid_d         = tid_nxt;
               addr_d        = addr_q + (ADDR_W'(len_q) << LINE_SHIFT);
               len_d         = len_nxt;
               if ((tid_q == TID_W'(NT - 1)) || (len_nxt == '0))
                  state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            pend_d = pend_q & ~thr_done;
            if (pend_d == '0)
               state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      if (start && (state_q != S_IDLE))
         err_d = 1'b1;
   end

   // State registers. An asynchronous reset drops any in-flight job.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         tid_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         len_q   <= '0;
         addr_q  <= '0;
         pend_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tid_q   <= tid_d;
         r_q     <= r_d;
         q_q     <= q_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end

   // The command fields read as zero whenever no command is offered.
   assign cmd_valid = (state_q == S_ISSUE);
   assign cmd_tid   = cmd_valid ? tid_q  : '0;
   assign cmd_addr  = cmd_valid ? addr_q : '0;
   assign cmd_len   = cmd_valid ? len_q  : '0;
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign err       = err_q;
endmodule

// File: doc/pm_thread_dispatch.md
# pm_thread_dispatch

Job splitter and dispatcher that sits directly upstream of the per-thread near-memory engines in the multi-thread design. A single `start` pulse launches a job descriptor (base address, length in cache lines). The block splits the job into up to 2**TID_W contiguous per-thread chunks and issues one command per thread over a valid/ready channel. It then collects per-thread completion pulses and reports job completion with a one-cycle `done`.

## Interface
- `TID_W`, default 2: thread-id width; thread count NT = 2**TID_W.
- `ADDR_W`, default 32: byte-address width.
- `LEN_W`, default 16: job/chunk length width, in lines.
- `LINE_SHIFT`, default 6: log2 of line size in bytes (64 B).

- `clk`  in  1  sole clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  job launch; sampled only in IDLE.
- `job_base`  in  ADDR_W  job byte base address, sampled with `start`.
- `job_len`  in  LEN_W  job length in lines, sampled with `start`.
- `cmd_valid`  out  1  per-thread command valid.
- `cmd_ready`  in  1  downstream accepts the command.
- `cmd_tid`  out  TID_W  target thread of the command.
- `cmd_addr`  out  ADDR_W  chunk byte address.
- `cmd_len`  out  LEN_W  chunk length in lines, always ≥1 when `cmd_valid` is high.
- `thr_done`  in  NT  per-thread completion pulses, bit i = thread i.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle job-complete pulse.
- `err`  out  1  sticky: a `start` arrived while busy; cleared by the next accepted `start`.

## Operation
- Reset values: all outputs 0; state IDLE; pending mask 0.
- Split rule: q = job_len >> TID_W, r = job_len mod NT.
  - Thread i length = q+1 for i < r, otherwise q.
  - Lengths are non-increasing in i.
- Address rule: addr_i = job_base + ((sum of lengths of threads < i) << LINE_SHIFT), computed mod 2**ADDR_W (wraps, no error).
- IDLE, `start`=1:
  - latch base, q, r; tid←0, offset←0, pending←0, err←0;
  - go to ISSUE, or to DONE if job_len==0.
- ISSUE:
  - `cmd_valid`=1 with registered payload for the current tid.
  - Payload is held stable until `cmd_valid && cmd_ready`.
  - On handshake: pending[tid]←1, offset += len, tid++.
  - Go to WAIT if tid was NT-1 or the next thread's length is 0; zero-length threads are never issued.
- WAIT: stay until pending==0, then go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `thr_done[i]` clears pending[i] in ISSUE and in WAIT. Bits not pending are ignored.
- On the handshake edge for thread i, the set of pending[i] wins over `thr_done[i]`. Threads never complete in their issue cycle.
- `start` outside IDLE: ignored, `err`←1. No other effect.
- `reset` mid-job: immediate return to IDLE. No `done`, no further commands; the in-flight command is dropped.

## Timing
- `start` sampled at edge T:
  - `cmd_valid` high in cycle T+1 (first command, no bubble);
  - `busy` high from T+1.
- Back-to-back commands: with `cmd_ready` held high, one command per cycle, NT commands in NT consecutive cycles.
- `done` is high in the cycle after the edge at which the last pending bit clears. `busy` stays high during the `done` cycle and falls the cycle after.
- job_len==0: `done` is high in cycle T+1 and no command is issued.
- A new `start` is accepted in the cycle after `done`, or later.

## Test plan
- **Even/uneven split:** base=0x1000, len=10, NT=4, ready=1.
  - Commands (tid,addr,len) = (0,0x1000,3), (1,0x10C0,3), (2,0x1180,2), (3,0x1200,2) in cycles T+1..T+4.
  - `thr_done` pulses 3,0,2,1 → `done` one cycle after the last pulse.
- **Short job:** len=2.
  - Only (0,base,1) and (1,base+0x40,1) are issued; threads 2/3 are never issued.
  - `done` follows both `thr_done` pulses; stray `thr_done[3]` is ignored.
- **Zero length:** len=0 → no `cmd_valid`, `done` in T+1, `busy` high for exactly one cycle.
- **Backpressure:** `cmd_ready` low for 5 cycles on command 1.
  - Payload is stable throughout and the handshake count is exactly 4.
  - An early `thr_done[0]` during ISSUE is honored.
- **Start while busy:** second `start` in WAIT → `err`=1, no new commands, the first job completes normally. The next accepted `start` clears `err`.
- **Address wrap and reset:**
  - base=0xFFFF_FFC0, len=4 → addrs 0xFFFF_FFC0, 0x0, 0x40, 0x80.
  - Assert `reset` after command 2 → all outputs 0 at once and no `done`.
